multi_pulse_gen: RTL

MULTI_PULSE_GEN -- requirements
Module: multi_pulse_gen

---
 rtl/multi_pulse_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/multi_pulse_gen.sv
// Multi-channel debounced edge-to-pulse generator with auto-repeat.
// Each channel debounces its level, detects mode-selected edges and repeats while held.
module multi_pulse_gen #(
    parameter int N             = 4,
    parameter int DEB_CYCLES    = 4,
    parameter int PULSE_W       = 1,
    parameter int REPEAT_EN     = 1,
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   level,
    input  logic [2*N-1:0] mode,
    output logic [N-1:0]   pulse,
    output logic [N-1:0]   held,
    output logic           any_pulse
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int PW   = $clog2(PULSE_W + 1);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_WAIT,
        REPEAT_WAIT
    } state_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [1:0]    md;
        logic [1:0]    md_q;
        logic [DW-1:0] deb_q, deb_d;
        logic          held_q, held_d;
        logic          pul_q, pul_d;
        logic [PW-1:0] wc_q, wc_d;
        logic [TW-1:0] tm_q, tm_d;
        state_t        st_q, st_d;
        logic          tog, qual, abort, arm, rpt;

        assign md = mode[2*i +: 2];

        always_ff @(posedge clk) begin
            if (reset) begin
                md_q   <= 2'b00;
                deb_q  <= '0;
                held_q <= 1'b0;
                pul_q  <= 1'b0;
                wc_q   <= '0;
                tm_q   <= '0;
                st_q   <= IDLE;
            end else begin
                md_q   <= md;
                deb_q  <= deb_d;
                held_q <= held_d;
                pul_q  <= pul_d;
                wc_q   <= wc_d;
                tm_q   <= tm_d;
                st_q   <= st_d;
            end
        end

        always_comb begin
            deb_d  = '0;
            held_d = held_q;
            tog    = 1'b0;
            if (level[i] != held_q) begin
                if (deb_q == DW'(DEB_CYCLES - 1)) begin
                    tog    = 1'b1;
                    held_d = ~held_q;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
        end

        // held_q is the pre-toggle value, so !held_q on a toggle means a rise
        assign qual  = tog & (((md == 2'b00) & ~held_q) |
                              ((md == 2'b01) &  held_q) |
                               (md == 2'b10));
        assign abort = (md != md_q);
        assign arm   = qual & (REPEAT_EN != 0) & ~md[1];

        always_comb begin
            st_d = st_q;
            tm_d = tm_q;
            rpt  = 1'b0;
            if (abort) begin
                st_d = IDLE;
                tm_d = '0;
            end else if (arm) begin
                st_d = HOLD_WAIT;
                tm_d = '0;
            end else if (tog) begin
                st_d = IDLE;
                tm_d = '0;
            end else begin
                unique case (st_q)
                    IDLE: tm_d = '0;
                    HOLD_WAIT: begin
                        if (tm_q == TW'(HOLD_CYCLES - 1)) begin
                            rpt  = 1'b1;
                            st_d = REPEAT_WAIT;
                            tm_d = '0;
                        end else begin
                            tm_d = tm_q + 1'b1;
                        end
                    end
                    REPEAT_WAIT: begin
                        if (tm_q == TW'(REPEAT_CYCLES - 1)) begin
                            rpt  = 1'b1;
                            tm_d = '0;
                        end else begin
                            tm_d = tm_q + 1'b1;
                        end
                    end
                    default: begin
                        st_d = IDLE;
                        tm_d = '0;
                    end
                endcase
            end
        end

        always_comb begin
            pul_d = pul_q;
            wc_d  = wc_q;
            if (abort) begin
                pul_d = 1'b0;
                wc_d  = '0;
            end else if (qual | rpt) begin
                pul_d = 1'b1;
                wc_d  = PW'(PULSE_W - 1);
            end else if (pul_q) begin
                if (wc_q == '0) pul_d = 1'b0;
                else            wc_d  = wc_q - 1'b1;
            end
        end

        assign held[i]  = held_q;
        assign pulse[i] = pul_q;
    end

    assign any_pulse = |pulse;

endmodule
